// File: rtl/axil_reg_pkg.sv
// Shared definitions for the AXI4-Lite register responder.
// Contents: AXI response codes and the write/read channel state encodings.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite link between an interconnect/VIP master and the register responder.
// Ports: AW, W, B, AR, R channels; master drives requests, slave drives responses.
interface axil_reg_responder_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_reg_bank.sv
// Register array with a byte-strobed write port and an asynchronous read port.
// Ports: clk/rst, we/wr_sel/wr_data/wr_strb (write), rd_sel/rd_data (read),
//        reg_q (all contents), reg_wr (one-cycle pulse per written register).
module axil_reg_bank #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [SEL_W-1:0]               wr_sel,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [SEL_W-1:0]               rd_sel,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Byte-lane write; reg_wr pulses even when no strobe bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs   <= '{default: '0};
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (we) begin
        for (int k = 0; k < DATA_WIDTH / 8; k++) begin
          if (wr_strb[k]) regs[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
        end
        reg_wr[wr_sel] <= 1'b1;
      end
    end
  end

  // Read returns the pre-edge value, so a same-edge write is not visible.
  assign rd_data = regs[rd_sel];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers to user logic.
// Ports: ACLK, ARESET (sync, active-high), bus (AXI4-Lite slave modport),
//        reg_q (register contents), reg_wr (per-register write pulse).
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_reg_responder_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  wr_state_e             ws, ws_n;
  rd_state_e             rs, rs_n;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_bits;

  assign unused_bits = ^{bus.AWPROT, bus.ARPROT, wr_addr[1:0], bus.ARADDR[1:0]};

  // Write channel: merge held and in-flight AW/W, decide commit and next state.
  always_comb begin
    ws_n    = ws;
    aw_hs   = bus.AWVALID && bus.AWREADY;
    w_hs    = bus.WVALID && bus.WREADY;
    wr_addr = aw_hs ? bus.AWADDR : aw_addr_q;
    wr_data = w_hs ? bus.WDATA : w_data_q;
    wr_strb = w_hs ? bus.WSTRB : w_strb_q;
    commit  = (aw_hs || ws == WR_HAVE_AW) && (w_hs || ws == WR_HAVE_W);
    wr_idx  = wr_addr[ADDR_WIDTH-1:2];
    wr_in_range = 32'(wr_idx) < NUM_REGS;
    case (ws)
      WR_IDLE: begin
        if (commit)     ws_n = WR_RESP;
        else if (aw_hs) ws_n = WR_HAVE_AW;
        else if (w_hs)  ws_n = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)       ws_n = WR_RESP;
      WR_HAVE_W:  if (aw_hs)      ws_n = WR_RESP;
      WR_RESP:    if (bus.BREADY) ws_n = WR_IDLE;
      default:                    ws_n = WR_IDLE;
    endcase
  end

  // Read channel next state.
  always_comb begin
    rs_n        = rs;
    ar_hs       = bus.ARVALID && bus.ARREADY;
    rd_idx      = bus.ARADDR[ADDR_WIDTH-1:2];
    rd_in_range = 32'(rd_idx) < NUM_REGS;
    case (rs)
      RD_IDLE: if (ar_hs)       rs_n = RD_RESP;
      RD_RESP: if (bus.RREADY)  rs_n = RD_IDLE;
      default:                  rs_n = RD_IDLE;
    endcase
  end

  // Write channel registers; READYs are derived from the next state so they
  // are low during reset and never depend on VALID combinationally.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ws          <= WR_IDLE;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= RESP_OKAY;
    end else begin
      ws          <= ws_n;
      bus.AWREADY <= (ws_n == WR_IDLE) || (ws_n == WR_HAVE_W);
      bus.WREADY  <= (ws_n == WR_IDLE) || (ws_n == WR_HAVE_AW);
      bus.BVALID  <= (ws_n == WR_RESP);
      if (aw_hs) aw_addr_q <= bus.AWADDR;
      if (w_hs) begin
        w_data_q <= bus.WDATA;
        w_strb_q <= bus.WSTRB;
      end
      if (commit) bus.BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rs          <= RD_IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= '0;
      bus.RRESP   <= RESP_OKAY;
    end else begin
      rs          <= rs_n;
      bus.ARREADY <= (rs_n == RD_IDLE);
      bus.RVALID  <= (rs_n == RD_RESP);
      if (ar_hs) begin
        bus.RDATA <= rd_in_range ? rd_data : '0;
        bus.RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axil_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .SEL_W      (SEL_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk     (ACLK),
    .rst     (ARESET),
    .we      (commit && wr_in_range),
    .wr_sel  (wr_idx[SEL_W-1:0]),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_sel  (rd_idx[SEL_W-1:0]),
    .rd_data (rd_data),
    .reg_q   (reg_q),
    .reg_wr  (reg_wr)
  );

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder with a B/R response scoreboard.
module tb_axil_reg_responder;
  import axil_reg_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned NR = 4;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_wr;

  always #5 ACLK = ~ACLK;

  axil_reg_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  typedef struct packed { logic [1:0] resp; logic [NR-1:0] wr; } b_exp_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] mdl [NR];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] mdl_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = mdl[i];
    return f;
  endfunction

  task automatic expect_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr[AW-1:2]);
    b_exp_t e;
    e.wr = '0;
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) if (strb[k]) mdl[idx][8*k +: 8] = data[8*k +: 8];
      e.resp = RESP_OKAY;
      e.wr[idx] = 1'b1;
    end else begin
      e.resp = RESP_SLVERR;
    end
    bq.push_back(e);
  endtask

  task automatic expect_read(input logic [AW-1:0] addr);
    int idx = int'(addr[AW-1:2]);
    r_exp_t e;
    e.data = (idx < NR) ? mdl[idx] : 32'h0;
    e.resp = (idx < NR) ? RESP_OKAY : RESP_SLVERR;
    rq.push_back(e);
  endtask

  task automatic send_aw(input logic [AW-1:0] addr);
    int n = 0;
    @(negedge ACLK);
    bus.AWADDR = addr;
    bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.AWREADY) check("aw_ready_timeout", 128'(bus.AWREADY), 128'd1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    @(negedge ACLK);
    bus.WDATA = data;
    bus.WSTRB = strb;
    bus.WVALID = 1'b1;
    while (!bus.WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.WREADY) check("w_ready_timeout", 128'(bus.WREADY), 128'd1);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] addr);
    int n = 0;
    @(negedge ACLK);
    bus.ARADDR = addr;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.ARREADY) check("ar_ready_timeout", 128'(bus.ARREADY), 128'd1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
  endtask

  // Pops the oldest expected B; chk_wr checks reg_wr in the first BVALID cycle.
  task automatic get_b(input string tag, input bit chk_wr, output int lat);
    int n = 0;
    b_exp_t e;
    @(negedge ACLK);
    while (!bus.BVALID && n < 50) begin @(negedge ACLK); n++; end
    lat = n;
    check({tag, "_bvalid"}, 128'(bus.BVALID), 128'd1);
    e = bq.pop_front();
    check({tag, "_bresp"}, 128'(bus.BRESP), 128'(e.resp));
    if (chk_wr) check({tag, "_reg_wr"}, 128'(reg_wr), 128'(e.wr));
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    check({tag, "_wready_after_b"}, 128'({bus.AWREADY, bus.WREADY, bus.BVALID}), 128'(3'b110));
  endtask

  task automatic get_r(input string tag);
    int n = 0;
    r_exp_t e;
    @(negedge ACLK);
    while (!bus.RVALID && n < 50) begin @(negedge ACLK); n++; end
    check({tag, "_rvalid"}, 128'(bus.RVALID), 128'd1);
    e = rq.pop_front();
    check({tag, "_rdata"}, 128'(bus.RDATA), 128'(e.data));
    check({tag, "_rresp"}, 128'(bus.RRESP), 128'(e.resp));
    bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    @(negedge ACLK);
    check({tag, "_arready_after_r"}, 128'({bus.ARREADY, bus.RVALID}), 128'(2'b10));
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int lat;
    expect_write(addr, data, strb);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    get_b(tag, 1'b1, lat);
    check({tag, "_lat"}, 128'(lat), 128'd0);
    check({tag, "_reg_q"}, 128'(reg_q), 128'(mdl_flat()));
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] addr);
    expect_read(addr);
    send_ar(addr);
    get_r(tag);
  endtask

  initial begin
    int lat;
    bit ok;
    logic [1:0]  b0;
    logic [31:0] r0;

    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_ready_low", 128'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 128'(3'b000));
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_ready_high", 128'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 128'(3'b111));
    check("rst_valid", 128'({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}), 128'd0);
    check("rst_rdata", 128'(bus.RDATA), 128'd0);
    check("rst_regs", 128'({reg_q, reg_wr}), 128'd0);

    // Sequential writes then read-back
    do_write("wr0", 6'h00, 32'h1, 4'hF);
    do_write("wr1", 6'h04, 32'h2, 4'hF);
    do_write("wr2", 6'h08, 32'h3, 4'hF);
    do_write("wr3", 6'h0C, 32'h4, 4'hF);
    do_read("rd0", 6'h00);
    do_read("rd1", 6'h04);
    do_read("rd2", 6'h08);
    do_read("rd3", 6'h0C);

    // W three cycles before AW
    expect_write(6'h08, 32'hDEADBEEF, 4'hF);
    send_w(32'hDEADBEEF, 4'hF);
    ok = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      ok &= !bus.WREADY && bus.AWREADY && !bus.BVALID;
    end
    check("w_first_hold", 128'(ok), 128'd1);
    send_aw(6'h08);
    get_b("w_first", 1'b1, lat);
    check("w_first_lat", 128'(lat), 128'd0);
    check("w_first_reg2", 128'(reg_q[64 +: 32]), 128'h0DEADBEEF);

    // Partial byte strobes
    do_write("strb_full", 6'h00, 32'h11223344, 4'hF);
    do_write("strb_part", 6'h00, 32'hAABBCCDD, 4'b0101);
    check("strb_reg0", 128'(reg_q[31:0]), 128'h11BB33DD);
    do_read("strb_rd", 6'h00);

    // Zero strobe in range: pulse only
    do_write("strb_zero", 6'h04, 32'hFFFFFFFF, 4'h0);

    // Out-of-range write and read
    do_write("oor_wr", 6'h10, 32'h12345678, 4'hF);
    do_read("oor_rd", 6'h10);
    do_read("oor_rd_hi", 6'h3C);

    // BREADY/RREADY stalled for 10 cycles
    expect_write(6'h04, 32'hCAFEF00D, 4'hF);
    expect_read(6'h08);
    fork
      send_aw(6'h04);
      send_w(32'hCAFEF00D, 4'hF);
      send_ar(6'h08);
    join
    @(negedge ACLK);
    b0 = bus.BRESP;
    r0 = bus.RDATA;
    check("stall_reg_wr", 128'(reg_wr), 128'(4'b0010));
    ok = 1'b1;
    repeat (10) begin
      ok &= bus.BVALID && bus.RVALID && (bus.BRESP === b0) && (bus.RDATA === r0);
      ok &= !bus.AWREADY && !bus.WREADY && !bus.ARREADY;
      @(negedge ACLK);
    end
    check("stall_stable", 128'(ok), 128'd1);
    get_b("stall_b", 1'b0, lat);
    get_r("stall_r");
    check("stall_reg_q", 128'(reg_q), 128'(mdl_flat()));

    // Read and write of the same register on the same edge: old value
    expect_read(6'h0C);
    expect_write(6'h0C, 32'h55AA55AA, 4'hF);
    fork
      send_aw(6'h0C);
      send_w(32'h55AA55AA, 4'hF);
      send_ar(6'h0C);
    join
    get_b("coll_b", 1'b1, lat);
    get_r("coll_r");
    check("coll_reg3", 128'(reg_q[96 +: 32]), 128'h55AA55AA);

    // Reset with AW held and W not yet sent
    send_aw(6'h00);
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    check("mid_rst_ready_low", 128'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 128'(3'b000));
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge ACLK);
    check("mid_rst_ready", 128'({bus.AWREADY, bus.WREADY, bus.BVALID}), 128'(3'b110));
    check("mid_rst_regs", 128'(reg_q), 128'd0);
    do_read("mid_rst_rd", 6'h00);
    do_write("post_rst_wr", 6'h04, 32'h0BADCAFE, 4'hF);
    do_read("post_rst_rd", 6'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI4-Lite slave (responder) register bank: the subordinate end of the AXI4-Lite link driven by the MicroBlaze interconnect or the master VIP. Provides NUM_REGS 32-bit read/write registers with byte strobes, independent AW/W acceptance, one outstanding write and one outstanding read, and SLVERR for out-of-range addresses. Register contents and a per-register write pulse are exported to user logic (decoder/encoder datapath).

## Interface
- DATA_WIDTH, 32, data bus width; only 32 supported
- ADDR_WIDTH, 6, byte address width
- NUM_REGS, 4, number of registers; valid byte addresses 0 .. 4*NUM_REGS-4
- ACLK  in  1  clock
- ARESET  in  1  reset; one clock; synchronous, active-high
- AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1  write address channel; AWPROT ignored
- AWREADY  out  1
- WDATA/WSTRB/WVALID  in  32/4/1  write data channel
- WREADY  out  1
- BRESP/BVALID  out  2/1; BREADY  in  1
- ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1; ARPROT ignored
- ARREADY  out  1
- RDATA/RRESP/RVALID  out  32/2/1; RREADY  in  1
- reg_q  out  NUM_REGS*32  current register contents, reg i at [32i+31:32i]
- reg_wr  out  NUM_REGS  one-cycle pulse, bit i high in the cycle after reg i is written

## Operation
- Address decode: index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored. index >= NUM_REGS -> out of range.
- Write path: AW and W accepted independently, each latched in a holding register (aw_held, w_held).
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - Commit when address and data both available (held, or handshaking this cycle): per byte lane k with WSTRB[k]=1, reg[index][8k+7:8k] <= WDATA[8k+7:8k]; clear holds; BVALID <= 1.
  - BRESP = OKAY (2'b00) in range, SLVERR (2'b10) out of range; out-of-range writes modify nothing and pulse no reg_wr.
  - WSTRB = 0 in range: OKAY, no register change, reg_wr still pulses.
  - BVALID held until BREADY; BRESP stable while BVALID.
- Read path: ARREADY = !RVALID. On AR handshake: RDATA <= reg[index] (0 if out of range), RRESP <= OKAY/SLVERR, RVALID <= 1. Hold until RREADY.
- Read/write collision: RDATA reflects register value before any write committing on the same edge (old value).
- States (write): IDLE, HAVE_AW, HAVE_W, RESP. IDLE->RESP on simultaneous AW+W; IDLE->HAVE_AW/HAVE_W on single handshake; HAVE_x->RESP on other handshake; RESP->IDLE on BREADY. Read: IDLE, RESP.

## Timing
- Reset values: AWREADY=WREADY=ARREADY=1 in cycle after reset deasserts (0 while ARESET high), BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, all registers 0, reg_wr=0.
- Write latency: last of AW/W handshakes in cycle N -> register updated, reg_wr, BVALID all visible in N+1.
- Read latency: AR handshake in cycle N -> RVALID/RDATA in N+1.
- Back-to-back: BVALID&&BREADY in cycle N -> AWREADY/WREADY high in N+1; same for read. Max throughput one write per 2 cycles, one read per 2 cycles; read and write paths fully concurrent.
- Reset mid-transaction: holds, BVALID, RVALID cleared; pending write not committed; registers cleared.
- VALID from master may rise without READY; READY does not depend combinationally on VALID.

## Structure
- Package axil_reg_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write-state enum, read-state enum.
- Sub-module axil_reg_bank: register array with byte-strobe write port, async read port, reg_wr generation; top holds the two channel FSMs.

## Test plan
- Sequential writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, full strobe, then read back -> RDATA 0x1..0x4, all BRESP/RRESP OKAY, reg_wr bits 0..3 pulse once each.
- W before AW by 3 cycles, WDATA 0xDEADBEEF to 0x8 -> WREADY low until B completes, reg2=0xDEADBEEF, BVALID one cycle after AW handshake.
- Reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg0=0x11BB33DD.
- Write/read to 0x10 (NUM_REGS=4) -> BRESP=SLVERR, no register change, RDATA=0, RRESP=SLVERR.
- BREADY/RREADY held low 10 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY/WREADY/ARREADY low throughout.
- ARESET asserted with AW held, W not yet sent -> after reset, BVALID=0, registers 0, AWREADY=WREADY=1; later read of 0x0 returns 0.
